// File: rtl/chip8_audio_pkg.sv
// chip8_audio_pkg: shared types for the CHIP-8 audio ADC receiver.
//   state_e      - capture FSM states
//   sample_t     - buffered sample {chan, data} at the default width
//   SAMPLE_W_DEF - default bits per channel word
package chip8_audio_pkg;

  localparam int SAMPLE_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_SHIFT,
    ST_PUSH
  } state_e;

  typedef struct packed {
    logic                    chan;
    logic [SAMPLE_W_DEF-1:0] data;
  } sample_t;

endpackage

// File: rtl/chip8_audio_fifo.sv
// chip8_audio_fifo: first-word fall-through FIFO.
//   clk, reset       - system clock, synchronous active-high reset
//   push, push_data  - write request and entry
//   pop_req          - consumer accepts head (pops only when valid)
//   head, valid      - oldest entry (0 when empty), non-empty flag
//   drop             - push refused because full with no pop this cycle
// DEPTH must be a power of two (>= 2) so pointers wrap naturally.
module chip8_audio_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_req,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full, pop, wr;

  always_comb begin
    valid    = (cnt_q != '0);
    full     = (cnt_q == (AW+1)'(DEPTH));
    pop      = valid & pop_req;
    // A pop frees the slot in the same edge, so a full FIFO still accepts.
    wr       = push & (~full | pop);
    drop     = push & full & ~pop;
    wr_ptr_d = wr  ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
    head     = valid ? mem_q[rd_ptr_q] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: head is masked while empty.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/chip8_audio_adc_rx.sv
// chip8_audio_adc_rx: I2S ADC receiver for the CHIP-8 audio codec.
//   clk, reset                       - system clock, sync active-high reset
//   aud_bclk, aud_adclrck, aud_adcdat - codec bit clock, channel clock
//                                      (0 left / 1 right), serial data;
//                                      all asynchronous to clk
//   sample_data, sample_chan,
//   sample_valid, sample_ready       - FWFT sample stream
//   overflow, frame_err, clear_flags - sticky error flags and their clear
//   peak_abs                         - max |sample| since reset/clear, only
//                                      when CHIP8_ADC_PEAK_EN is defined
module chip8_audio_adc_rx
  import chip8_audio_pkg::*;
#(
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                aud_bclk,
  input  logic                aud_adclrck,
  input  logic                aud_adcdat,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_chan,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overflow,
  output logic                frame_err,
  input  logic                clear_flags
`ifdef CHIP8_ADC_PEAK_EN
  ,
  output logic [SAMPLE_W-1:0] peak_abs
`endif
);

  localparam int CW = $clog2(SAMPLE_W + 1);

  // Synchronizers; bclk_s3_q is the edge-detect history.
  logic bclk_s1_q, bclk_s2_q, bclk_s3_q;
  logic lrck_s1_q, lrck_s2_q, lrck_prev_q;
  logic dat_s1_q, dat_s2_q;
  logic [1:0] settle_q, settle_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_s1_q   <= 1'b0;
      bclk_s2_q   <= 1'b0;
      bclk_s3_q   <= 1'b0;
      lrck_s1_q   <= 1'b0;
      lrck_s2_q   <= 1'b0;
      lrck_prev_q <= 1'b0;
      dat_s1_q    <= 1'b0;
      dat_s2_q    <= 1'b0;
    end else begin
      bclk_s1_q   <= aud_bclk;
      bclk_s2_q   <= bclk_s1_q;
      bclk_s3_q   <= bclk_s2_q;
      lrck_s1_q   <= aud_adclrck;
      lrck_s2_q   <= lrck_s1_q;
      lrck_prev_q <= lrck_s2_q;
      dat_s1_q    <= aud_adcdat;
      dat_s2_q    <= dat_s1_q;
    end
  end

  // After reset the LRCK chain fills from 0; ignore that fill so a word only
  // starts on a real edge seen once the chain holds the live level.
  logic settled, bclk_rise, lrck_chg;

  always_comb begin
    settled   = (settle_q == 2'd3);
    settle_d  = settled ? settle_q : settle_q + 2'd1;
    bclk_rise = bclk_s2_q & ~bclk_s3_q;
    lrck_chg  = settled & (lrck_s2_q != lrck_prev_q);
  end

  // Capture FSM
  state_e              state_q, state_d;
  logic                chan_q, chan_d;
  logic [SAMPLE_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]       bitcnt_q, bitcnt_d;
  logic                push, ferr_set;

  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (lrck_chg) begin
          state_d = ST_SKIP;
          chan_d  = lrck_s2_q;
        end
      end
      ST_SKIP: begin
        if (lrck_chg) begin
          ferr_set = 1'b1;
          chan_d   = lrck_s2_q;
        end else if (bclk_rise) begin
          state_d  = ST_SHIFT;
          bitcnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (lrck_chg) begin
          ferr_set = 1'b1;
          chan_d   = lrck_s2_q;
          state_d  = ST_SKIP;
        end else if (bclk_rise) begin
          shreg_d  = {shreg_q[SAMPLE_W-2:0], dat_s2_q};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == CW'(SAMPLE_W - 1)) state_d = ST_PUSH;
        end
      end
      ST_PUSH: begin
        push = 1'b1;
        // A (very fast) LRCK edge landing here still starts the next word.
        if (lrck_chg) begin
          state_d = ST_SKIP;
          chan_d  = lrck_s2_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sample buffer
  logic [SAMPLE_W:0] head;
  logic              drop;

  chip8_audio_fifo #(
    .WIDTH (SAMPLE_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({chan_q, shreg_q}),
    .pop_req   (sample_ready),
    .head      (head),
    .valid     (sample_valid),
    .drop      (drop)
  );

  assign {sample_chan, sample_data} = head;

  // Sticky flags; clear wins over a same-cycle set.
  logic overflow_q, overflow_d, frame_err_q, frame_err_d;

  always_comb begin
    overflow_d  = clear_flags ? 1'b0 : (overflow_q | drop);
    frame_err_d = clear_flags ? 1'b0 : (frame_err_q | ferr_set);
  end

  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      settle_q    <= '0;
      state_q     <= ST_IDLE;
      chan_q      <= 1'b0;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      settle_q    <= settle_d;
      state_q     <= state_d;
      chan_q      <= chan_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef CHIP8_ADC_PEAK_EN
  // |v| with the most negative code saturated to the largest positive one.
  function automatic logic [SAMPLE_W-1:0] sat_abs(input logic [SAMPLE_W-1:0] v);
    if (!v[SAMPLE_W-1]) return v;
    if (v == {1'b1, {(SAMPLE_W-1){1'b0}}}) return {1'b0, {(SAMPLE_W-1){1'b1}}};
    return ~v + 1'b1;
  endfunction

  logic [SAMPLE_W-1:0] peak_q, peak_d, mag;

  // Tracks every completed word, including one the full buffer drops.
  always_comb begin
    mag    = sat_abs(shreg_q);
    peak_d = peak_q;
    if (clear_flags)                 peak_d = '0;
    else if (push && (mag > peak_q)) peak_d = mag;
  end

  always_ff @(posedge clk) begin
    if (reset) peak_q <= '0;
    else       peak_q <= peak_d;
  end

  assign peak_abs = peak_q;
`endif

endmodule

// File: tb/tb_chip8_audio_adc_rx.sv
module tb_chip8_audio_adc_rx;
  import chip8_audio_pkg::*;

  localparam int W = 16;
  localparam int D = 4;

  logic         clk = 1'b0, reset = 1'b1;
  logic         aud_bclk = 1'b0, aud_adclrck = 1'b1, aud_adcdat = 1'b0;
  logic         sample_ready = 1'b0, clear_flags = 1'b0;
  logic [W-1:0] sample_data;
  logic         sample_chan, sample_valid, overflow, frame_err;
`ifdef CHIP8_ADC_PEAK_EN
  logic [W-1:0] peak_abs;
`endif

  always #5 clk = ~clk;

  chip8_audio_adc_rx #(.SAMPLE_W(W), .FIFO_DEPTH(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .aud_bclk     (aud_bclk),
    .aud_adclrck  (aud_adclrck),
    .aud_adcdat   (aud_adcdat),
    .sample_data  (sample_data),
    .sample_chan  (sample_chan),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overflow     (overflow),
    .frame_err    (frame_err),
    .clear_flags  (clear_flags)
`ifdef CHIP8_ADC_PEAK_EN
    ,
    .peak_abs     (peak_abs)
`endif
  );

  int      vectors = 0, errors = 0;
  sample_t exp_q[$];
  sample_t pop_log[$];
  bit      exp_ovf = 0, exp_ferr = 0, mid_word = 0, in_reset = 1;
  int      exp_peak = 0;
  int      ready_mode = 0;  // 0 hold low, 1 hold high, 2 random
  int      hp = 4;          // BCLK half period in clk cycles (>= 4)

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Consumer handshake, applied 2 units after each edge.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       sample_ready = 1'b0;
      1:       sample_ready = 1'b1;
      default: sample_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (!in_reset) begin
      chk("valid", {31'b0, sample_valid}, {31'b0, exp_q.size() != 0});
      if (sample_valid && exp_q.size() != 0) begin
        chk("head", {15'b0, sample_chan, sample_data}, {15'b0, exp_q[0]});
        if (sample_ready) begin
          pop_log.push_back(sample_t'({sample_chan, sample_data}));
          void'(exp_q.pop_front());
        end
      end
      chk("overflow", {31'b0, overflow}, {31'b0, exp_ovf});
      chk("frame_err", {31'b0, frame_err}, {31'b0, exp_ferr});
`ifdef CHIP8_ADC_PEAK_EN
      chk("peak_abs", {16'b0, peak_abs}, exp_peak);
`endif
    end
  end

  // Model: a completed word enters the buffer unless it is already full.
  task automatic model_push(input sample_t s);
    int v, a;
    if (exp_q.size() < D) exp_q.push_back(s);
    else                  exp_ovf = 1;
    v = int'($signed(s.data));
    a = (v < 0) ? -v : v;
    if (a > 32767) a = 32767;
    if (a > exp_peak) exp_peak = a;
    mid_word = 0;
  endtask

  // One BCLK period: falling edge (data/LRCK change), then rising edge.
  // Model events land after the two synchronizer flops plus the detect/FSM
  // stage: LRCK effects 3 clks after the change, a pushed word 4 clks after
  // the rise carrying its last bit.
  task automatic slot(input bit d, input bit lr_ev, input bit lr, input bit push_ev,
                      input sample_t s, input bit pulse);
    aud_bclk   = 1'b0;
    aud_adcdat = d;
    if (lr_ev) aud_adclrck = lr;
    for (int i = 1; i <= hp; i++) begin
      @(posedge clk); #1;
      if (lr_ev && i == 3) begin
        if (mid_word) exp_ferr = 1;
        mid_word = 1;
      end
    end
    aud_bclk = 1'b1;
    for (int i = 1; i <= hp; i++) begin
      @(posedge clk); #1;
      if (pulse && i == 3) ready_mode = 1;
      if (i == 4) begin
        if (pulse) ready_mode = 0;
        if (push_ev) model_push(s);
      end
    end
  endtask

  // I2S frame on the opposite channel: skip slot, nbits MSB-first, pad slots.
  task automatic frame(input logic [W-1:0] data, input int nbits, input int pad, input bit pulse);
    sample_t s;
    bit      lr;
    lr     = ~aud_adclrck;
    s.chan = lr;
    s.data = data;
    slot(1'($urandom_range(0, 1)), 1'b1, lr, 1'b0, s, 1'b0);
    for (int b = 0; b < nbits; b++)
      slot(data[W-1-b], 1'b0, 1'b0, (b == W-1), s, pulse && (b == W-1));
    for (int p = 0; p < pad; p++)
      slot(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, s, 1'b0);
  endtask

  task automatic do_reset();
    in_reset = 1;
    reset    = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    exp_ovf  = 0;
    exp_ferr = 0;
    exp_peak = 0;
    mid_word = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, sample_valid}, 0);
    chk("rst_data", {15'b0, sample_chan, sample_data}, 0);
    chk("rst_flags", {30'b0, overflow, frame_err}, 0);
`ifdef CHIP8_ADC_PEAK_EN
    chk("rst_peak", {16'b0, peak_abs}, 0);
`endif
    reset    = 1'b0;
    in_reset = 0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear_flags = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
    exp_ovf  = 0;
    exp_ferr = 0;
    exp_peak = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    ready_mode = 1;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: run did not complete within time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    do_reset();

    // Left 0x8001 then right 0x7FFE, consumer always ready.
    ready_mode = 1;
    pop_log.delete();
    frame(16'h8001, 16, 2, 1'b0);
    frame(16'h7FFE, 16, 2, 1'b0);
    chk("lr_pops", pop_log.size(), 2);
    if (pop_log.size() == 2) begin
      chk("lr_pop0", {15'b0, pop_log[0]}, 32'h0_8001);
      chk("lr_pop1", {15'b0, pop_log[1]}, 32'h1_7FFE);
    end

    // Five words into a 4-deep buffer with no consumer.
    ready_mode = 0;
    pop_log.delete();
    frame(16'h1111, 16, 1, 1'b0);
    frame(16'h2222, 16, 1, 1'b0);
    frame(16'h3333, 16, 1, 1'b0);
    frame(16'h4444, 16, 1, 1'b0);
    frame(16'h5555, 16, 1, 1'b0);
    chk("ovf_set", {31'b0, overflow}, 1);
    drain();
    chk("ovf_pops", pop_log.size(), 4);
    if (pop_log.size() == 4) begin
      chk("ovf_pop0", {15'b0, pop_log[0]}, 32'h0_1111);
      chk("ovf_pop1", {15'b0, pop_log[1]}, 32'h1_2222);
      chk("ovf_pop2", {15'b0, pop_log[2]}, 32'h0_3333);
      chk("ovf_pop3", {15'b0, pop_log[3]}, 32'h1_4444);
    end
    do_clear();
    chk("ovf_clear", {31'b0, overflow}, 0);

    // LRCK toggles after 9 bits, then a full word.
    pop_log.delete();
    frame(16'hABCD, 9, 0, 1'b0);
    frame(16'h1234, 16, 1, 1'b0);
    chk("ferr_set", {31'b0, frame_err}, 1);
    chk("ferr_pops", pop_log.size(), 1);
    if (pop_log.size() == 1) chk("ferr_pop0", {15'b0, pop_log[0]}, 32'h0_1234);
    do_clear();
    chk("ferr_clear", {31'b0, frame_err}, 0);

    // Reset at bit 8 of a word; the rest of that word must not be captured.
    pop_log.delete();
    frame(16'h5A5A, 8, 0, 1'b0);
    do_reset();
    for (int b = 8; b < 18; b++) begin
      sample_t s0;
      s0 = '0;
      slot(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, s0, 1'b0);
    end
    chk("rst_nosample", {31'b0, sample_valid}, 0);
    chk("rst_nopops", pop_log.size(), 0);
    frame(16'hC3C3, 16, 1, 1'b0);
    chk("rst_next_pops", pop_log.size(), 1);
    if (pop_log.size() == 1) chk("rst_next_pop", {15'b0, pop_log[0]}, 32'h0_C3C3);

    // Full buffer, push and pop on the same edge.
    ready_mode = 0;
    pop_log.delete();
    frame(16'h0A01, 16, 1, 1'b0);
    frame(16'h0A02, 16, 1, 1'b0);
    frame(16'h0A03, 16, 1, 1'b0);
    frame(16'h0A04, 16, 1, 1'b0);
    frame(16'h0A05, 16, 1, 1'b1);
    chk("full_pp_ovf", {31'b0, overflow}, 0);
    drain();
    chk("full_pp_pops", pop_log.size(), 5);
    if (pop_log.size() == 5) begin
      chk("full_pp_first", {15'b0, pop_log[0]}, 32'h1_0A01);
      chk("full_pp_last", {15'b0, pop_log[4]}, 32'h1_0A05);
    end

`ifdef CHIP8_ADC_PEAK_EN
    do_clear();
    ready_mode = 1;
    frame(16'h0100, 16, 1, 1'b0);
    chk("peak_0100", {16'b0, peak_abs}, 32'h0100);
    frame(16'hFE00, 16, 1, 1'b0);
    chk("peak_fe00", {16'b0, peak_abs}, 32'h0200);
    frame(16'h8000, 16, 1, 1'b0);
    chk("peak_8000", {16'b0, peak_abs}, 32'h7FFF);
`endif

    // Randomized frames, truncations, BCLK rates and consumer stalls.
    ready_mode = 2;
    for (int f = 0; f < 60; f++) begin
      hp = $urandom_range(4, 6);
      frame(16'($urandom()),
            ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : 16,
            $urandom_range(0, 3), 1'b0);
    end
    hp = 4;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
